alu_seq: RTL

//  Registered, parametrised successor of the combinational 6502 ALU: same op set

---
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered 6502-style ALU with valid/ready handshakes on both sides.
// Binary ops produce a result 1 cycle after accept; decimal ADD/SUB take 2 cycles.
module alu_seq #(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [4:0]       mode,
  input  logic             carry_in,
  input  logic             decimal_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             sign,
  output logic [1:0]       dbg_state
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Once
  // out_valid is high, alu_out and all flags stay stable until that transfer.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ADJ  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [4:0] M_ADD = 5'd0;
  localparam logic [4:0] M_AND = 5'd1;
  localparam logic [4:0] M_OR  = 5'd2;
  localparam logic [4:0] M_EOR = 5'd3;
  localparam logic [4:0] M_ROR = 5'd4;
  localparam logic [4:0] M_SUB = 5'd5;
  localparam logic [4:0] M_ASL = 5'd6;
  localparam logic [4:0] M_ROL = 5'd7;
  localparam logic [4:0] M_LSR = 5'd8;

  localparam int NIB    = (WIDTH / 4 > 0) ? WIDTH / 4 : 1;
  localparam bit DEC_OK = DECIMAL_EN && (WIDTH % 4 == 0);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       mode_q;
  logic             cin_q;
  logic             dec_q;
  logic [4:0]       nib_q   [NIB];

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             is_dec;
  logic [4:0]       nib_raw [NIB];
  logic [WIDTH-1:0] dec_res;
  logic             dec_c;
  logic [5:0]       t;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_HOLD);
  assign dbg_state = state;
  assign is_dec    = DEC_OK && dec_q && (mode_q == M_ADD || mode_q == M_SUB);

  // Binary result; SUB is a + ~b + cin so C=1 means no borrow.
  always_comb begin
    b_eff = (mode_q == M_SUB) ? ~b_q : b_q;
    sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_q};
    res   = a_q;
    res_c = cin_q;
    res_v = 1'b0;
    case (mode_q)
      M_ADD, M_SUB: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      M_AND: res = a_q & b_q;
      M_OR:  res = a_q | b_q;
      M_EOR: res = a_q ^ b_q;
      M_ROR: begin
        res   = {cin_q, a_q[WIDTH-1:1]};
        res_c = a_q[0];
      end
      M_ASL: begin
        res   = {a_q[WIDTH-2:0], 1'b0};
        res_c = a_q[WIDTH-1];
      end
      M_ROL: begin
        res   = {a_q[WIDTH-2:0], cin_q};
        res_c = a_q[WIDTH-1];
      end
      M_LSR: begin
        res   = {1'b0, a_q[WIDTH-1:1]};
        res_c = a_q[0];
      end
      default: ;
    endcase
  end

  // Per-nibble sums without carry-in; the carry chain is applied during ADJ.
  always_comb begin
    for (int i = 0; i < NIB; i++) begin
      nib_raw[i] = {1'b0, a_q[4*i +: 4]} + {1'b0, b_eff[4*i +: 4]};
    end
  end

  // Decimal adjust, LSB nibble first, with the decimal carry rippling upward.
  always_comb begin
    dec_res = '0;
    dec_c   = cin_q;
    t       = '0;
    for (int i = 0; i < NIB; i++) begin
      t = {1'b0, nib_q[i]} + {5'd0, dec_c};
      if (mode_q == M_SUB) begin
        if (t < 6'd16) begin
          t     = t - 6'd6;
          dec_c = 1'b0;
        end else begin
          dec_c = 1'b1;
        end
      end else begin
        if (t > 6'd9) begin
          t     = t + 6'd6;
          dec_c = 1'b1;
        end else begin
          dec_c = 1'b0;
        end
      end
      dec_res[4*i +: 4] = t[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      alu_out   <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      sign      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q    <= alu_a;
            b_q    <= alu_b;
            mode_q <= mode;
            cin_q  <= carry_in;
            dec_q  <= decimal_in;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out   <= res;
          carry_out <= res_c;
          overflow  <= res_v;
          zero      <= (res == '0);
          sign      <= res[WIDTH-1];
          nib_q     <= nib_raw;
          state     <= is_dec ? S_ADJ : S_HOLD;
        end
        // Z/V/N keep the binary-result values written in EXEC.
        S_ADJ: begin
          alu_out   <= dec_res;
          carry_out <= dec_c;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
